// File: rtl/m_trap_csr_unit_pkg.sv
// Shared CSR addresses, interrupt cause codes and CSR operation encoding
// for the machine-mode trap CSR block.
package m_trap_csr_unit_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  localparam logic [4:0] INT_MSI = 5'd3;
  localparam logic [4:0] INT_MTI = 5'd7;
  localparam logic [4:0] INT_MEI = 5'd11;

  localparam logic [31:0] MIE_MASK   = 32'h0000_0888;
  localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFD;
  localparam logic [31:0] MEPC_MASK  = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  function automatic logic [31:0] csr_apply(csr_op_e op, logic [31:0] old_val,
                                            logic [31:0] wdata);
    case (op)
      CSR_OP_RW: return wdata;
      CSR_OP_RS: return old_val | wdata;
      CSR_OP_RC: return old_val & ~wdata;
      default:   return old_val;
    endcase
  endfunction

endpackage

// File: rtl/m_trap_csr_unit_irq_sync.sv
// Multi-flop synchroniser for one asynchronous interrupt line.
module irq_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr <= '0;
    else     sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/m_trap_csr_unit.sv
// Machine-mode trap CSR block: trap state, interrupt arbitration, trap target
// generation and the mcycle/minstret counters.
module m_trap_csr_unit
  import m_trap_csr_unit_pkg::*;
#(
  parameter int unsigned RETIRE_PORTS = 2,
  parameter logic [31:0] MTVEC_RESET  = 32'h0000_0000,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [11:0]                     csr_addr,
  input  logic [1:0]                      csr_op,
  input  logic [31:0]                     csr_wdata,
  input  logic                            csr_commit,
  output logic [31:0]                     csr_rdata,
  output logic                            csr_illegal,
  input  logic                            exc_valid,
  input  logic [4:0]                      exc_code,
  input  logic [31:0]                     exc_pc,
  input  logic [31:0]                     exc_tval,
  input  logic                            interrupt_take,
  input  logic [31:0]                     interrupt_pc,
  input  logic                            mret,
  input  logic [$clog2(RETIRE_PORTS):0]   retire_count,
  input  logic                            ext_irq,
  input  logic                            timer_irq,
  input  logic                            sw_irq,
  output logic                            interrupt_pending,
  output logic [31:0]                     exception_target_pc,
  output logic [31:0]                     epc
);

  logic        status_mie, status_mpie;
  logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [63:0] mcycle_q, minstret_q, mcycle_d, minstret_d;
  logic        meip, mtip, msip;
  logic [31:0] mip, irq_en, tvec_base, csr_new;
  logic [4:0]  int_code;
  logic        int_any, pend_q, csr_wr;

  irq_sync #(.STAGES(SYNC_STAGES)) u_sync_ext (.clk(clk), .rst(rst), .d(ext_irq),   .q(meip));
  irq_sync #(.STAGES(SYNC_STAGES)) u_sync_tmr (.clk(clk), .rst(rst), .d(timer_irq), .q(mtip));
  irq_sync #(.STAGES(SYNC_STAGES)) u_sync_sw  (.clk(clk), .rst(rst), .d(sw_irq),    .q(msip));

  assign mip     = {20'b0, meip, 3'b0, mtip, 3'b0, msip, 3'b0};
  assign irq_en  = mip & mie_q;
  assign int_any = |irq_en;

  always_comb begin
    int_code = '0;
    if (irq_en[11])     int_code = INT_MEI;
    else if (irq_en[3]) int_code = INT_MSI;
    else if (irq_en[7]) int_code = INT_MTI;
  end

  // Purely combinational from current state so the control unit can latch it
  // in the same cycle it asserts interrupt_take.
  assign tvec_base = {mtvec_q[31:2], 2'b00};
  assign exception_target_pc = (mtvec_q[0] && !exc_valid && int_any)
                               ? tvec_base + {25'b0, int_code, 2'b00}
                               : tvec_base;

  always_comb begin
    csr_rdata   = '0;
    csr_illegal = 1'b0;
    case (csr_addr)
      CSR_MSTATUS:   csr_rdata = {24'b0, status_mpie, 3'b0, status_mie, 3'b0};
      CSR_MIE:       csr_rdata = mie_q;
      CSR_MTVEC:     csr_rdata = mtvec_q;
      CSR_MSCRATCH:  csr_rdata = mscratch_q;
      CSR_MEPC:      csr_rdata = mepc_q;
      CSR_MCAUSE:    csr_rdata = mcause_q;
      CSR_MTVAL:     csr_rdata = mtval_q;
      CSR_MIP:       csr_rdata = mip;
      CSR_MCYCLE:    csr_rdata = mcycle_q[31:0];
      CSR_MCYCLEH:   csr_rdata = mcycle_q[63:32];
      CSR_MINSTRET:  csr_rdata = minstret_q[31:0];
      CSR_MINSTRETH: csr_rdata = minstret_q[63:32];
      default:       csr_illegal = 1'b1;
    endcase
  end

  assign csr_new = csr_apply(csr_op_e'(csr_op), csr_rdata, csr_wdata);
  assign csr_wr  = csr_commit && (csr_op != CSR_OP_NONE) && !csr_illegal &&
                   !exc_valid && !interrupt_take && !mret;

  // Counters advance even when a trap drops the CSR write; a write to a half
  // replaces the whole next value of that counter.
  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + 64'(retire_count);
    if (csr_wr) begin
      case (csr_addr)
        CSR_MCYCLE:    mcycle_d   = {mcycle_q[63:32], csr_new};
        CSR_MCYCLEH:   mcycle_d   = {csr_new, mcycle_q[31:0]};
        CSR_MINSTRET:  minstret_d = {minstret_q[63:32], csr_new};
        CSR_MINSTRETH: minstret_d = {csr_new, minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_mie  <= 1'b0;
      status_mpie <= 1'b0;
      mie_q       <= '0;
      mtvec_q     <= MTVEC_RESET;
      mscratch_q  <= '0;
      mepc_q      <= '0;
      mcause_q    <= '0;
      mtval_q     <= '0;
      mcycle_q    <= '0;
      minstret_q  <= '0;
      pend_q      <= 1'b0;
    end else begin
      pend_q     <= status_mie & int_any;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      if (exc_valid) begin
        mepc_q      <= exc_pc & MEPC_MASK;
        mcause_q    <= {1'b0, 26'b0, exc_code};
        mtval_q     <= exc_tval;
        status_mpie <= status_mie;
        status_mie  <= 1'b0;
      end else if (interrupt_take) begin
        mepc_q      <= interrupt_pc & MEPC_MASK;
        mcause_q    <= {1'b1, 26'b0, int_code};
        mtval_q     <= '0;
        status_mpie <= status_mie;
        status_mie  <= 1'b0;
      end else if (mret) begin
        status_mie  <= status_mpie;
        status_mpie <= 1'b1;
      end else if (csr_wr) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            status_mie  <= csr_new[3];
            status_mpie <= csr_new[7];
          end
          CSR_MIE:      mie_q      <= csr_new & MIE_MASK;
          CSR_MTVEC:    mtvec_q    <= csr_new & MTVEC_MASK;
          CSR_MSCRATCH: mscratch_q <= csr_new;
          CSR_MEPC:     mepc_q     <= csr_new & MEPC_MASK;
          CSR_MCAUSE:   mcause_q   <= csr_new;
          CSR_MTVAL:    mtval_q    <= csr_new;
          default: ;
        endcase
      end
    end
  end

  assign interrupt_pending = pend_q;
  assign epc               = mepc_q;

`ifndef SYNTHESIS
  exc_int_exclusive: assert property (@(posedge clk) disable iff (rst)
                                      !(exc_valid && interrupt_take));
`endif

endmodule
